// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU-select decode, load-use bubble and operand forwarding
// Optional build macro ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding onto the ALU operands.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [RA_W-1:0]  rs_addr_i,
  input  logic [RA_W-1:0]  rt_addr_i,
  input  logic [RA_W-1:0]  rd_addr_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic             alu_src_i,
  input  logic             reg_dst_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             exmem_reg_write_i,
  input  logic [RA_W-1:0]  exmem_rd_i,
  input  logic [WIDTH-1:0] exmem_result_i,
  input  logic             memwb_reg_write_i,
  input  logic [RA_W-1:0]  memwb_rd_i,
  input  logic [WIDTH-1:0] memwb_result_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_sel_o,
  output logic [WIDTH-1:0] store_data_o,
  output logic [RA_W-1:0]  ex_dest_o,
  output logic             ex_valid_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             load_use_hazard_o,
  output logic             illegal_op_o
);

  logic             valid_q, reg_write_q, mem_read_q, mem_write_q, alu_src_q, illegal_q;
  logic [2:0]       sel_q, sel_d;
  logic             illegal_d;
  logic [RA_W-1:0]  dest_q, rs_addr_q, rt_addr_q;
  logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic             hazard, clear;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  always_comb begin
    sel_d     = 3'b010;
    illegal_d = 1'b0;
    unique case (alu_op_i)
      2'b00: sel_d = 3'b010;
      2'b01: sel_d = 3'b110;
      2'b11: sel_d = 3'b001;
      default: begin
        unique case (funct_i)
          6'b100000: sel_d = 3'b010;
          6'b100010: sel_d = 3'b110;
          6'b100100: sel_d = 3'b000;
          6'b100101: sel_d = 3'b001;
          6'b101010: sel_d = 3'b111;
          6'b100110: sel_d = 3'b100;
          6'b000000: sel_d = 3'b011;
          default: begin
            sel_d     = 3'b011;
            illegal_d = in_valid_i;
          end
        endcase
      end
    endcase
  end

  // A load in EX whose destination feeds this ID instruction cannot be forwarded in time.
  assign hazard = valid_q & mem_read_q & (dest_q != '0) &
                  ((dest_q == rs_addr_i) | ((dest_q == rt_addr_i) & ~alu_src_i)) & in_valid_i;

  // Flush wins over stall; a hazard under stall is a plain hold.
  assign clear = rst_i | flush_i | (~stall_i & hazard);

  always_ff @(posedge clk_i) begin
    if (clear) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      illegal_q   <= 1'b0;
      sel_q       <= 3'b000;
      dest_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
    end else if (!stall_i) begin
      valid_q     <= in_valid_i;
      reg_write_q <= reg_write_i & in_valid_i;
      mem_read_q  <= mem_read_i & in_valid_i;
      mem_write_q <= mem_write_i & in_valid_i;
      alu_src_q   <= alu_src_i;
      illegal_q   <= illegal_d;
      sel_q       <= sel_d;
      dest_q      <= reg_dst_i ? rd_addr_i : rt_addr_i;
      rs_addr_q   <= rs_addr_i;
      rt_addr_q   <= rt_addr_i;
      rs_data_q   <= rs_data_i;
      rt_data_q   <= rt_data_i;
      imm_q       <= imm_i;
    end
  end

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == rs_addr_q)
      fwd_rs = exmem_result_i;
    else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == rs_addr_q)
      fwd_rs = memwb_result_i;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == rt_addr_q)
      fwd_rt = exmem_result_i;
    else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == rt_addr_q)
      fwd_rt = memwb_result_i;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                        memwb_reg_write_i, memwb_rd_i, memwb_result_i, rs_addr_q, rt_addr_q};
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
`endif

  assign alu_a_o           = fwd_rs;
  assign store_data_o      = fwd_rt;
  assign alu_b_o           = alu_src_q ? imm_q : fwd_rt;
  assign alu_sel_o         = sel_q;
  assign ex_dest_o         = dest_q;
  assign ex_valid_o        = valid_q;
  assign ex_reg_write_o    = reg_write_q;
  assign ex_mem_read_o     = mem_read_q;
  assign ex_mem_write_o    = mem_write_q;
  assign illegal_op_o      = illegal_q;
  assign load_use_hazard_o = hazard;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU. It latches decoded operands and control each cycle.
- Decodes alu_op/funct into the 3-bit ALU select and applies EX/MEM and MEM/WB forwarding to the ALU operands.
- Detects load-use hazards and inserts a bubble when one occurs.
- All outputs feed the ALU (a, b, sel) and the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width
- RA_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID stage holds a valid instruction
stall  in  1  hold all registers
flush  in  1  replace the stage contents with a bubble
rs_data  in  WIDTH  register-file read port 1
rt_data  in  WIDTH  register-file read port 2
imm  in  WIDTH  sign-extended immediate
rs_addr  in  RA_W  source register 1
rt_addr  in  RA_W  source register 2
rd_addr  in  RA_W  R-type destination
alu_op  in  2  main-decoder ALU class
funct  in  6  R-type function field
alu_src  in  1  1 = operand b is imm
reg_dst  in  1  1 = destination is rd, 0 = rt
reg_write  in  1  instruction writes the register file
mem_read  in  1  load instruction
mem_write  in  1  store instruction
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  RA_W  EX/MEM destination
exmem_result  in  WIDTH  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  RA_W  MEM/WB destination
memwb_result  in  WIDTH  MEM/WB writeback value
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
alu_sel  out  3  ALU select
store_data  out  WIDTH  forwarded rt for stores
ex_dest  out  RA_W  registered destination
ex_valid  out  1  stage holds a valid instruction
ex_reg_write  out  1  registered control bit
ex_mem_read  out  1  registered control bit
ex_mem_write  out  1  registered control bit
load_use_hazard  out  1  ID must hold this cycle
illegal_op  out  1  valid R-type with unsupported funct

Behaviour:
- Update priority at each rising clk edge: rst > flush > stall > load_use_hazard > normal load.
- rst: all registers clear to 0. As a result, ex_valid, every ex_* control bit, alu_sel=000, ex_dest, alu_a, alu_b and store_data are all 0.
- flush: same as rst, but for the pipeline contents only. Takes effect on the next edge; the hazard output is ignored.
- stall: all registers hold their values. A stall and a hazard in the same cycle resolve as a hold; no bubble is inserted.
- load_use_hazard (combinational): asserted when ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==rs_addr | (ex_dest==rt_addr & !alu_src)) & in_valid.
  - When the hazard is asserted and stall=0, the stage loads a bubble (valid=0, controls=0).
  - Upstream holds IF/ID in that cycle.
- Normal load: latches all data, addresses and control bits; ex_valid<=in_valid.
  - Control bits are gated by in_valid, so an invalid instruction latches all-zero controls.
  - ex_dest latches reg_dst ? rd_addr : rt_addr.
- alu_sel is decoded at load time and registered:
  - alu_op 00 -> 010 (add, used by lw/sw/addi)
  - alu_op 01 -> 110 (sub, used by beq)
  - alu_op 11 -> 001 (or, used by ori)
  - alu_op 10 -> decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, 100110->100, 000000->011 (nop), any other funct -> 011.
- illegal_op: registered. Set only for a valid instruction with alu_op=10 and an unlisted funct; otherwise 0.
- Forwarding (combinational, from registered rs/rt addresses), for each source register:
  - Use EX/MEM if exmem_reg_write & exmem_rd!=0 & match.
  - Otherwise use MEM/WB if memwb_reg_write & memwb_rd!=0 & match.
  - Otherwise use the registered register-file data.
  - EX/MEM always beats MEM/WB.
- Operand selection:
  - alu_a = forwarded rs.
  - store_data = forwarded rt.
  - alu_b = alu_src ? registered imm : forwarded rt.
- Register $0 is never forwarded.
- Latency: one cycle from the ID inputs to the ALU operands. Forwarding adds no cycles.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding behaves as described above.
- Undefined: forwarding logic is omitted.
  - alu_a, alu_b and store_data come straight from the registered rs_data/rt_data/imm.
  - The exmem_*/memwb_* ports remain but are ignored.
  - Load-use hazard detection is unchanged.

Test Plan:
- rst=1 for 2 cycles with all inputs at 1 -> every output is 0, alu_sel=000.
- Load R-type, funct=100010, rs_data=9, rt_data=4, no forwarding -> next cycle alu_sel=110, alu_a=9, alu_b=4, ex_valid=1.
- Latched rs=3; exmem_rd=3 with result 0x11 and memwb_rd=3 with result 0x22, both writing -> alu_a=0x11. With exmem_rd=0 -> alu_a=0x22.
- lw to $5 in the stage, then an ID instruction with rs=5 -> load_use_hazard=1 and the next cycle ex_valid=0. With stall also high -> contents held and no bubble.
- alu_op=10, funct=111111, in_valid=1 -> alu_sel=011, illegal_op=1. The same with in_valid=0 -> illegal_op=0 and controls 0.
- Loaded instruction, then flush=1 together with stall=1 -> the next cycle shows a bubble (ex_valid=0, ex_reg_write=0).
